cx_fpu_seq: RTL
===============

# cx_fpu_seq

Sequencer for the custom-0 (opcode 0x0B) instruction group. It accepts one decoded custom instruction from the CPU core and sequences the shared single-precision FP adder and FP multiplier over req/ack handshakes to produce `dsqa` ((rs1−rs2)²) and `xfsq` (rs1²). It computes `mac` (rd + rs1[15:0]·rs2[15:0]) locally. It returns one result per instruction to the CPU writeback path and sits between the core's execute stage and the FP units.

## Interface
Parameters:
- `TIMEOUT`, default 64. Maximum cycles a unit request may stay unacknowledged. Must be ≥2.
- `MAC_SIGNED`, default 0. Selects the 16×16 product type: 0 = unsigned, 1 = signed.

Ports:
- `clk`  in  1  Clock. Everything is sampled on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `ins_valid`  in  1  CPU offers an instruction.
- `ins_ready`  out  1  High only in IDLE.
- `ins_funct3`  in  3  Operation select: 000 mac, 001 xfsq, 010 dsqa; all other codes are illegal.
- `ins_rs1`, `ins_rs2`  in  32  Source operands.
- `ins_rd_val`  in  32  Current rd value, used only by mac.
- `res_valid`  out  1  One-cycle result strobe.
- `res_data`  out  32  Result. Valid while `res_valid` is high.
- `res_illegal`  out  1  Qualifies `res_valid`: the funct3 was illegal.
- `res_timeout`  out  1  Qualifies `res_valid`: a unit failed to acknowledge.
- `fadd_req`  out  1  FP add request.
- `fadd_a`, `fadd_b`  out  32  FP add operands.
- `fadd_ack`  in  1  One-cycle acknowledge from the adder.
- `fadd_res`  in  32  Adder result, valid with `fadd_ack`.
- `fmul_req`  out  1  FP multiply request.
- `fmul_a`, `fmul_b`  out  32  FP multiply operands.
- `fmul_ack`  in  1  One-cycle acknowledge from the multiplier.
- `fmul_res`  in  32  Multiplier result, valid with `fmul_ack`.

## Operation
- **States:** IDLE, ADD_WAIT, MUL_WAIT, MAC, DONE.
- **IDLE:**
  - `ins_ready`=1.
  - On `ins_valid`, latch the operands and funct3.
  - Next state: dsqa→ADD_WAIT, xfsq→MUL_WAIT, mac→MAC, illegal→DONE (`res_data`=0, `res_illegal`=1).
- **ADD_WAIT:**
  - `fadd_req`=1, `fadd_a`=rs1, `fadd_b`=rs2 with bit 31 inverted.
  - On `fadd_ack`, latch `fadd_res` as d and go to MUL_WAIT with `fmul_a`=`fmul_b`=d.
- **MUL_WAIT:**
  - `fmul_req`=1. Operands are rs1/rs1 for xfsq and d/d for dsqa.
  - On `fmul_ack`, latch `fmul_res` into `res_data` and go to DONE.
- **MAC:**
  - `res_data` = rd_val + product(rs1[15:0], rs2[15:0]), modulo 2³².
  - The product is zero- or sign-extended to 32 bits according to `MAC_SIGNED`.
  - Next state is DONE.
- **DONE:** `res_valid`=1 for exactly one cycle, then IDLE.
- **Handshake rules:**
  - A req is registered and held high, with its operands stable, until the cycle its ack is sampled.
  - The req is low in the following cycle.
  - Acks received outside the matching wait state are ignored.
  - `fadd_req` and `fmul_req` are never high together.
- **Timeout:**
  - A wait counter clears on entry to ADD_WAIT or MUL_WAIT and increments every cycle without an ack.
  - When it reaches `TIMEOUT`−1 with no ack, the block drops the req and goes to DONE with `res_timeout`=1 and `res_data`=0.
  - An ack arriving in that same cycle wins; no timeout is flagged.
- **Reset values:**
  - State IDLE.
  - `ins_ready`=1.
  - All req, `res_*` and flag outputs are 0.
  - `res_data` and all operand outputs are 0.
- **Reset mid-operation:** the next edge forces IDLE and drops any req. No `res_valid` is produced for the aborted instruction.

## Timing
- T = the accept cycle (`ins_valid` && `ins_ready`).
- `ins_ready` is low from T+1 until `res_valid` has been high for one cycle. The next accept is earliest at the cycle after `res_valid`.
- **mac:** `res_valid` at T+2.
- **illegal funct3:** `res_valid` at T+1.
- **xfsq:** `fmul_req` rises at T+1. With the ack at cycle A, `res_valid` is at A+1. Minimum latency is T+2 (ack in the first req cycle).
- **dsqa:**
  - `fadd_req` spans T+1..A1.
  - `fmul_req` spans A1+1..A2.
  - `res_valid` is at A2+1. Minimum latency is T+3.
- **Timeout:** the req is high for exactly `TIMEOUT` cycles, and `res_valid` follows in the next cycle.

## Test plan
- **dsqa:** rs1=0x420A3D71, rs2=0x4091EB85.
  - Required: `fadd_a`=0x420A3D71 and `fadd_b`=0xC091EB85.
  - The model acks with 0x41F00000 after 3 cycles. Required: `fmul_a`=`fmul_b`=0x41F00000.
  - The model acks with 0x44610000. Required: `res_data`=0x44610000, no flags.
- **xfsq:** rs1=0x420A3D71, rs2=0x12345678.
  - Required: `fmul_a`=`fmul_b`=0x420A3D71, and `fadd_req` is never asserted.
  - The model acks with 0x44954C99. Required: `res_data`=0x44954C99.
- **mac:** rd_val=3, rs1=0x00010005, rs2=0xFFFF0007. Required: `res_data`=0x26 at T+2.
  - Repeat with `MAC_SIGNED`=1 and rs1=0x0000FFFE (−2), rs2=3, rd_val=10. Required: `res_data`=4.
- **Illegal funct3=111:** required `res_valid` at T+1 with `res_illegal`=1 and `res_data`=0, and no unit req.
- **Timeout:** `TIMEOUT`=8, xfsq, `fmul_ack` tied low.
  - Required: `fmul_req` high for exactly 8 cycles, then `res_timeout`=1 and `res_data`=0.
  - A stray `fmul_ack` one cycle later is ignored, and the next instruction completes normally.
- **Reset mid-dsqa:** assert `reset` during ADD_WAIT.
  - Required at the next edge: `fadd_req`=0 and `ins_ready`=1.
  - A late `fadd_ack` produces no `res_valid`.
  - A new xfsq issued afterwards returns the correct result.

Source files
------------

// File: rtl/cx_fpu_seq.sv
// Sequencer for the custom-0 instruction group: drives the shared FP adder and
// multiplier for dsqa/xfsq over req/ack, computes mac locally, one result per instruction.
module cx_fpu_seq #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned MAC_SIGNED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [2:0]  ins_funct3,
  input  logic [31:0] ins_rs1,
  input  logic [31:0] ins_rs2,
  input  logic [31:0] ins_rd_val,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_illegal,
  output logic        res_timeout,
  output logic        fadd_req,
  output logic [31:0] fadd_a,
  output logic [31:0] fadd_b,
  input  logic        fadd_ack,
  input  logic [31:0] fadd_res,
  output logic        fmul_req,
  output logic [31:0] fmul_a,
  output logic [31:0] fmul_b,
  input  logic        fmul_ack,
  input  logic [31:0] fmul_res
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] F3_MAC  = 3'b000;
  localparam logic [2:0] F3_XFSQ = 3'b001;
  localparam logic [2:0] F3_DSQA = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD_WAIT = 3'd1,
    S_MUL_WAIT = 3'd2,
    S_MAC      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       mac_a_q, mac_a_d;
  logic [15:0]       mac_b_q, mac_b_d;
  logic [31:0]       rd_q, rd_d;
  logic              ins_ready_q, ins_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_illegal_q, res_illegal_d;
  logic              res_timeout_q, res_timeout_d;
  logic              fadd_req_q, fadd_req_d;
  logic [31:0]       fadd_a_q, fadd_a_d;
  logic [31:0]       fadd_b_q, fadd_b_d;
  logic              fmul_req_q, fmul_req_d;
  logic [31:0]       fmul_a_q, fmul_a_d;
  logic [31:0]       fmul_b_q, fmul_b_d;

  logic              mac_sx_s;
  logic [31:0]       mac_a_ext_s, mac_b_ext_s, mac_prod_s;

  // 16x16 product; low 32 bits of the extended-operand product equal the signed product mod 2^32
  always_comb begin
    mac_sx_s    = (MAC_SIGNED != 32'd0);
    mac_a_ext_s = {{16{mac_sx_s & mac_a_q[15]}}, mac_a_q};
    mac_b_ext_s = {{16{mac_sx_s & mac_b_q[15]}}, mac_b_q};
    mac_prod_s  = mac_a_ext_s * mac_b_ext_s;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mac_a_d       = mac_a_q;
    mac_b_d       = mac_b_q;
    rd_d          = rd_q;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_illegal_d = 1'b0;
    res_timeout_d = 1'b0;
    fadd_req_d    = fadd_req_q;
    fadd_a_d      = fadd_a_q;
    fadd_b_d      = fadd_b_q;
    fmul_req_d    = fmul_req_q;
    fmul_a_d      = fmul_a_q;
    fmul_b_d      = fmul_b_q;

    case (state_q)
      S_IDLE: begin
        if (ins_valid) begin
          mac_a_d = ins_rs1[15:0];
          mac_b_d = ins_rs2[15:0];
          rd_d    = ins_rd_val;
          cnt_d   = '0;
          case (ins_funct3)
            F3_DSQA: begin
              state_d    = S_ADD_WAIT;
              fadd_req_d = 1'b1;
              fadd_a_d   = ins_rs1;
              fadd_b_d   = {~ins_rs2[31], ins_rs2[30:0]};
            end
            F3_XFSQ: begin
              state_d    = S_MUL_WAIT;
              fmul_req_d = 1'b1;
              fmul_a_d   = ins_rs1;
              fmul_b_d   = ins_rs1;
            end
            F3_MAC: begin
              state_d = S_MAC;
            end
            default: begin
              state_d       = S_DONE;
              res_valid_d   = 1'b1;
              res_illegal_d = 1'b1;
              res_data_d    = 32'h0000_0000;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD_WAIT: begin
        if (fadd_ack) begin
          state_d    = S_MUL_WAIT;
          fadd_req_d = 1'b0;
          fmul_req_d = 1'b1;
          fmul_a_d   = fadd_res;
          fmul_b_d   = fadd_res;
          cnt_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_DONE;
          fadd_req_d    = 1'b0;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          res_data_d    = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MUL_WAIT: begin
        if (fmul_ack) begin
          state_d     = S_DONE;
          fmul_req_d  = 1'b0;
          res_valid_d = 1'b1;
          res_data_d  = fmul_res;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_DONE;
          fmul_req_d    = 1'b0;
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          res_data_d    = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MAC: begin
        state_d     = S_DONE;
        res_valid_d = 1'b1;
        res_data_d  = rd_q + mac_prod_s;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        fadd_req_d = 1'b0;
        fmul_req_d = 1'b0;
      end
    endcase

    ins_ready_d = (state_d == S_IDLE);
  end

  // State and registered-output flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mac_a_q       <= 16'h0000;
      mac_b_q       <= 16'h0000;
      rd_q          <= 32'h0000_0000;
      ins_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
      res_data_q    <= 32'h0000_0000;
      res_illegal_q <= 1'b0;
      res_timeout_q <= 1'b0;
      fadd_req_q    <= 1'b0;
      fadd_a_q      <= 32'h0000_0000;
      fadd_b_q      <= 32'h0000_0000;
      fmul_req_q    <= 1'b0;
      fmul_a_q      <= 32'h0000_0000;
      fmul_b_q      <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mac_a_q       <= mac_a_d;
      mac_b_q       <= mac_b_d;
      rd_q          <= rd_d;
      ins_ready_q   <= ins_ready_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_illegal_q <= res_illegal_d;
      res_timeout_q <= res_timeout_d;
      fadd_req_q    <= fadd_req_d;
      fadd_a_q      <= fadd_a_d;
      fadd_b_q      <= fadd_b_d;
      fmul_req_q    <= fmul_req_d;
      fmul_a_q      <= fmul_a_d;
      fmul_b_q      <= fmul_b_d;
    end
  end

  assign ins_ready   = ins_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_illegal = res_illegal_q;
  assign res_timeout = res_timeout_q;
  assign fadd_req    = fadd_req_q;
  assign fadd_a      = fadd_a_q;
  assign fadd_b      = fadd_b_q;
  assign fmul_req    = fmul_req_q;
  assign fmul_a      = fmul_a_q;
  assign fmul_b      = fmul_b_q;

endmodule
